// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM and BCD MM:SS.cc time base with button edge detection.
// Optional lap-freeze display is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100,
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bt_start,
  input  logic       bt_clr,
  input  logic       bt_lap,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_cs,
  output logic       running,
  output logic       overflow,
  output logic       lap_active
);

  // state   | meaning
  // S_IDLE  | cleared, waiting for start
  // S_RUN   | prescaler and time counter advancing
  // S_PAUSE | counting frozen, prescaler phase kept
  // S_DONE  | saturated at MAX_MIN:59.99

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [3:0] MAXM_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAXM_O = 4'(MAX_MIN % 10);
  localparam logic [23:0] TIME_MAX = {MAXM_T, MAXM_O, 4'd5, 4'd9, 4'd9, 4'd9};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      prev_q, press_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [23:0]     time_q, time_d;
  logic            running_q, overflow_q;
  logic            tick, at_max, start_p, clr_p;
  logic [23:0]     disp_time;

  // Digit order in time vector: [3:0]=cs ones ... [23:20]=min tens.
  function automatic logic [23:0] time_inc(input logic [23:0] t);
    logic [23:0] r;
    logic        carry;
    logic [3:0]  lim;
    r     = t;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3) ? 4'd5 : 4'd9;
      if (carry) begin
        if (r[i*4 +: 4] == lim) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign start_p = press_q[0];
  assign clr_p   = press_q[1];
  assign tick    = (state_q == S_RUN) && (cnt_q == CNT_MAX);
  assign at_max  = (time_q == TIME_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    time_d  = time_q;
    if (state_q == S_RUN) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    if (tick && !at_max) begin
      time_d = time_inc(time_q);
    end
    case (state_q)
      S_IDLE:  if (start_p) state_d = S_RUN;
      S_RUN: begin
        if (tick && at_max) state_d = S_DONE;
        else if (start_p)   state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (clr_p)        state_d = S_IDLE;
        else if (start_p) state_d = S_RUN;
      end
      S_DONE:  if (clr_p) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE && state_q != S_IDLE) begin
      cnt_d  = '0;
      time_d = '0;
    end
  end

  // prev regs reset high so a button held through reset is not a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      prev_q     <= 2'b11;
      press_q    <= 2'b00;
      cnt_q      <= '0;
      time_q     <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= {bt_clr, bt_start};
      press_q    <= {bt_clr, bt_start} & ~prev_q;
      cnt_q      <= cnt_d;
      time_q     <= time_d;
      running_q  <= (state_d == S_RUN);
      overflow_q <= (state_d == S_DONE);
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        lap_prev_q, lap_press_q, lap_q, lap_d;
  logic [23:0] frz_q, frz_d;

  always_comb begin
    lap_d = lap_q;
    frz_d = frz_q;
    if (state_d == S_IDLE || state_d == S_DONE) begin
      lap_d = 1'b0;
    end else if (lap_press_q) begin
      if (lap_q && (state_q == S_RUN || state_q == S_PAUSE)) begin
        lap_d = 1'b0;
      end else if (!lap_q && state_q == S_RUN) begin
        lap_d = 1'b1;
        frz_d = time_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_prev_q  <= 1'b1;
      lap_press_q <= 1'b0;
      lap_q       <= 1'b0;
      frz_q       <= '0;
    end else begin
      lap_prev_q  <= bt_lap;
      lap_press_q <= bt_lap & ~lap_prev_q;
      lap_q       <= lap_d;
      frz_q       <= frz_d;
    end
  end

  assign disp_time  = lap_q ? frz_q : time_q;
  assign lap_active = lap_q;
`else
  logic unused_lap;
  assign unused_lap = bt_lap;
  assign disp_time  = time_q;
  assign lap_active = 1'b0;
`endif

  assign disp_min = disp_time[23:16];
  assign disp_sec = disp_time[15:8];
  assign disp_cs  = disp_time[7:0];
  assign running  = running_q;
  assign overflow = overflow_q;

endmodule
